// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned iterative restoring divider. It produces one quotient bit per
//   clock and returns the quotient and remainder of an NBITS dividend divided
//   by an NBITS divisor. Each trial subtraction is a single NBITS+1 bit
//   carry-lookahead add of a + ~b with cin=1. A carry-out of 1 means there
//   was no borrow.
//
//   Optional build macro: DIVIDER_DBZ_DETECT_EN
//     When defined, a zero divisor is detected on the accepting edge.
//     The FSM then goes straight to DONE with dbz=1.
//     When undefined, dbz is tied low and a zero divisor runs the full
//     NBITS iterations. The quotient and remainder come out the same
//     in both builds.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous reset, active low
//   start      in   1      request, sampled only while busy=0
//   dividend   in   NBITS  numerator, captured on the accepting edge
//   divisor    in   NBITS  denominator, captured on the accepting edge
//   busy       out  1      high whenever the FSM is not IDLE
//   done       out  1      one-cycle pulse; results are valid from this cycle
//   quotient   out  NBITS  result, held until the next done
//   remainder  out  NBITS  result, held until the next done
//   dbz        out  1      divide-by-zero flag, qualified by done
// -----------------------------------------------------------------------------

// Plain W-bit carry-lookahead adder. Every carry is built as a flat
// sum of products of generate/propagate terms, so no carry is rippled
// from the previous bit position.
module carrylookahead #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g, p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];
endmodule

module seq_restoring_divider #(
    parameter int NBITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] remainder,
    output logic             dbz
);
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [NBITS-1:0] a_q, q_q, m_q;
    logic [NBITS-1:0] quotient_q, remainder_q;

    // Trial subtraction of the divisor from the partial remainder,
    // with the next dividend bit shifted in.
    logic [NBITS:0]   s, t;
    logic             no_borrow;
    logic [NBITS-1:0] a_d, q_d;
    logic             unused_t_msb;

    assign s = {a_q, q_q[NBITS-1]};

    carrylookahead #(.W(NBITS + 1)) u_sub (
        .a    (s),
        .b    (~{1'b0, m_q}),
        .cin  (1'b1),
        .sum  (t),
        .cout (no_borrow)
    );

    // The top bit of the difference is always zero when there is no
    // borrow, because the partial remainder stays below the divisor.
    assign unused_t_msb = t[NBITS];

    assign a_d = no_borrow ? t[NBITS-1:0] : s[NBITS-1:0];
    assign q_d = {q_q[NBITS-2:0], no_borrow};

`ifdef DIVIDER_DBZ_DETECT_EN
    logic dbz_q;
    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIVIDER_DBZ_DETECT_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= '0;
                        q_q     <= dividend;
                        m_q     <= divisor;
                        count_q <= CW'(NBITS);
`ifdef DIVIDER_DBZ_DETECT_EN
                        if (divisor == '0) begin
                            // Short-circuit: the result is known without iterating.
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        quotient_q  <= q_d;
                        remainder_q <= a_d;
                        state_q     <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;
    localparam int NBITS = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [NBITS-1:0] dividend = '0;
    logic [NBITS-1:0] divisor = '0;
    logic             busy, done, dbz;
    logic [NBITS-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    seq_restoring_divider #(.NBITS(NBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request. lat is the number of edges (accepting edge = 1)
    // after which done is first seen high. A run is cut off at 20 edges.
    task automatic run_div(input logic [NBITS-1:0] n, input logic [NBITS-1:0] d, output int lat);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int dones;
    logic [NBITS-1:0] vn [5] = '{6'd63, 6'd5, 6'd0, 6'd62, 6'd45};
    logic [NBITS-1:0] vd [5] = '{6'd1, 6'd9, 6'd17, 6'd62, 6'd7};
    logic [NBITS-1:0] vq [5] = '{6'd63, 6'd0, 6'd0, 6'd1, 6'd6};
    logic [NBITS-1:0] vr [5] = '{6'd0, 6'd5, 6'd0, 6'd0, 6'd3};

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", dbz, 0);
        rst_n = 1'b1;
        tick();

        // 45/7 with cycle-by-cycle timing
        dividend = 6'd45; divisor = 6'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_e1", busy, 1);
        chk("t1_done_e1", done, 0);
        for (int e = 2; e <= 6; e++) begin
            tick();
            chk("t1_done_early", done, 0);
            chk("t1_busy_run", busy, 1);
        end
        tick();
        chk("t1_done_e7", done, 1);
        chk("t1_busy_e7", busy, 1);
        chk("t1_q", quotient, 6);
        chk("t1_r", remainder, 3);
        chk("t1_dbz", dbz, 0);
        tick();
        chk("t1_done_e8", done, 0);
        chk("t1_busy_e8", busy, 0);
        chk("t1_q_hold", quotient, 6);

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            run_div(vn[i], vd[i], lat);
            chk("t2_lat", lat, 7);
            chk("t2_q", quotient, vq[i]);
            chk("t2_r", remainder, vr[i]);
            tick();
        end

        // Divide by zero
        run_div(6'd13, 6'd0, lat);
`ifdef DIVIDER_DBZ_DETECT_EN
        chk("t3_lat", lat, 1);
        chk("t3_dbz", dbz, 1);
`else
        chk("t3_lat", lat, 7);
        chk("t3_dbz", dbz, 0);
`endif
        chk("t3_q", quotient, 63);
        chk("t3_r", remainder, 13);
        tick();
        // The flag clears on the next accept.
        run_div(6'd20, 6'd3, lat);
        chk("t3_dbz_clr", dbz, 0);
        chk("t3b_q", quotient, 6);
        chk("t3b_r", remainder, 2);
        tick();

        // A start pulse during RUN is ignored
        dividend = 6'd45; divisor = 6'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        dividend = 6'd20; divisor = 6'd4; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk("t4_lat", lat, 7);
        chk("t4_q", quotient, 6);
        chk("t4_r", remainder, 3);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
            chk("t4_q_hold", quotient, 6);
            chk("t4_r_hold", remainder, 3);
        end
        chk("t4_no_extra_done", dones, 0);

        // Reset in the middle of RUN
        dividend = 6'd45; divisor = 6'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_q", quotient, 0);
        chk("t5_r", remainder, 0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dones++;
        end
        chk("t5_no_done", dones, 0);
        run_div(6'd20, 6'd4, lat);
        chk("t5_lat", lat, 7);
        chk("t5_q", quotient, 5);
        chk("t5_r", remainder, 0);
        tick();

        // start held high with a random operand stream, checked against a model
        begin
            int ops = 0;
            int cyc = 0;
            logic [NBITS-1:0] pn = '0, pd = '0;
            logic [NBITS-1:0] eq, er;
            start = 1'b1;
            while (ops < 200 && cyc < 3000) begin
                dividend = NBITS'($urandom_range(0, 63));
                divisor  = NBITS'($urandom_range(0, 63));
                if (!busy) begin
                    pn = dividend;
                    pd = divisor;
                end
                tick();
                cyc++;
                if (done) begin
                    if (pd == 0) begin
                        eq = '1;
                        er = pn;
                    end else begin
                        eq = pn / pd;
                        er = pn % pd;
                    end
                    chk("t6_q", quotient, eq);
                    chk("t6_r", remainder, er);
`ifdef DIVIDER_DBZ_DETECT_EN
                    chk("t6_dbz", dbz, (pd == 0) ? 1 : 0);
`else
                    chk("t6_dbz", dbz, 0);
`endif
                    ops++;
                end
            end
            start = 1'b0;
            chk("t6_ops", ops, 200);
            // With start held high the stream cannot finish faster than one
            // op per 8 cycles, except for short-circuited zero divisors.
`ifndef DIVIDER_DBZ_DETECT_EN
            chk("t6_cycles", cyc, 200 * 8 - 1);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
